// File: rtl/age_queue_sel.sv
`default_nettype none
// ============================================================================
// Module  : age_queue_sel
// Brief   : Circular age-ordered queue with wrap-bit pointers, flush, wakeup
//           and registered oldest-ready select.
// Revision: 1.0
// ============================================================================
module age_queue_sel #(
    parameter int DEPTH = 64,
    parameter int PTR_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             alloc_vld,
    output logic             alloc_rdy,
    output logic [PTR_W-1:0] alloc_ptr,
    input  logic             wake_vld,
    input  logic [PTR_W-1:0] wake_idx,
    input  logic             issue_ack,
    output logic             sel_vld,
    output logic [PTR_W-1:0] sel_idx,
    input  logic             retire_vld,
    input  logic             flush_vld,
    input  logic [PTR_W-1:0] flush_ptr,
    output logic [DEPTH-1:0] valid_vec,
    output logic [PTR_W:0]   count,
    output logic             empty,
    output logic             full
);

    localparam logic [PTR_W:0] C_PTR_ONE = 1;

    logic [PTR_W:0]   in_ptr_q,  in_ptr_d;
    logic [PTR_W:0]   out_ptr_q, out_ptr_d;
    logic [DEPTH-1:0] valid_q,   valid_d;
    logic [DEPTH-1:0] ready_q,   ready_d;
    logic [DEPTH-1:0] issued_q,  issued_d;
    logic             sel_vld_q, sel_vld_d;
    logic [PTR_W-1:0] sel_idx_q, sel_idx_d;

    logic [PTR_W-1:0] w_in_idx;
    logic [PTR_W-1:0] w_out_idx;
    logic             w_full;
    logic             w_empty;
    logic             w_do_alloc;
    logic             w_do_retire;
    logic             w_do_flush;
    logic             w_flush_wrap;
    logic [DEPTH-1:0] w_clr;
    logic [DEPTH-1:0] w_cand;
    logic [DEPTH-1:0] w_rot;
    logic [PTR_W-1:0] w_first;

    // Distance from the oldest entry; larger means younger.
    function automatic logic [PTR_W-1:0] age_of(input logic [PTR_W-1:0] idx,
                                                 input logic [PTR_W-1:0] base);
        age_of = idx - base;
    endfunction

    assign w_in_idx  = in_ptr_q[PTR_W-1:0];
    assign w_out_idx = out_ptr_q[PTR_W-1:0];
    assign w_empty   = (in_ptr_q == out_ptr_q);
    assign w_full    = (w_in_idx == w_out_idx) && (in_ptr_q[PTR_W] != out_ptr_q[PTR_W]);

    assign w_do_alloc  = alloc_vld & ~w_full & ~flush_vld;
    assign w_do_retire = retire_vld & ~w_empty;
    assign w_do_flush  = flush_vld & valid_q[flush_ptr];
    // The surviving entry sits in the out lap if its index is not below out.
    assign w_flush_wrap = (flush_ptr >= w_out_idx) ? out_ptr_q[PTR_W] : ~out_ptr_q[PTR_W];

    always_comb begin
        in_ptr_d  = in_ptr_q;
        out_ptr_d = out_ptr_q;
        valid_d   = valid_q;
        ready_d   = ready_q;
        issued_d  = issued_q;
        w_clr     = '0;

        if (w_do_flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (valid_q[i] && (age_of(PTR_W'(i), w_out_idx) > age_of(flush_ptr, w_out_idx)))
                    w_clr[i] = 1'b1;
            end
        end
        if (w_do_retire)
            w_clr[w_out_idx] = 1'b1;

        if (wake_vld && valid_q[wake_idx])
            ready_d[wake_idx] = 1'b1;
        if (issue_ack && sel_vld_q)
            issued_d[sel_idx_q] = 1'b1;

        // Flush/retire clears override any wake or issue on the same entry.
        valid_d  = valid_d  & ~w_clr;
        ready_d  = ready_d  & ~w_clr;
        issued_d = issued_d & ~w_clr;

        if (w_do_alloc) begin
            valid_d[w_in_idx]  = 1'b1;
            ready_d[w_in_idx]  = 1'b0;
            issued_d[w_in_idx] = 1'b0;
            in_ptr_d           = in_ptr_q + C_PTR_ONE;
        end
        if (w_do_retire)
            out_ptr_d = out_ptr_q + C_PTR_ONE;
        if (w_do_flush)
            in_ptr_d = {w_flush_wrap, flush_ptr} + C_PTR_ONE;
    end

    // Oldest-first pick on next state so sel never names a stale entry.
    always_comb begin
        w_cand  = valid_d & ready_d & ~issued_d;
        w_rot   = '0;
        w_first = '0;
        for (int i = 0; i < DEPTH; i++)
            w_rot[i] = w_cand[PTR_W'(i) + out_ptr_d[PTR_W-1:0]];
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (w_rot[i])
                w_first = PTR_W'(i);
        end
        sel_vld_d = |w_rot;
        sel_idx_d = w_first + out_ptr_d[PTR_W-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_ptr_q  <= '0;
            out_ptr_q <= '0;
            valid_q   <= '0;
            ready_q   <= '0;
            issued_q  <= '0;
            sel_vld_q <= 1'b0;
            sel_idx_q <= '0;
        end else begin
            in_ptr_q  <= in_ptr_d;
            out_ptr_q <= out_ptr_d;
            valid_q   <= valid_d;
            ready_q   <= ready_d;
            issued_q  <= issued_d;
            sel_vld_q <= sel_vld_d;
            sel_idx_q <= sel_idx_d;
        end
    end

    assign alloc_rdy = ~w_full;
    assign alloc_ptr = w_in_idx;
    assign sel_vld   = sel_vld_q;
    assign sel_idx   = sel_idx_q;
    assign valid_vec = valid_q;
    assign count     = in_ptr_q - out_ptr_q;
    assign empty     = w_empty;
    assign full      = w_full;

endmodule
`default_nettype wire

// File: tb/tb_age_queue_sel.sv
`default_nettype none
// ============================================================================
// Module  : tb_age_queue_sel
// Brief   : Scoreboard bench for age_queue_sel (DEPTH=8) against a walking model.
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_age_queue_sel;

    localparam int DEPTH = 8;
    localparam int PTR_W = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             alloc_vld = 1'b0;
    logic             alloc_rdy;
    logic [PTR_W-1:0] alloc_ptr;
    logic             wake_vld = 1'b0;
    logic [PTR_W-1:0] wake_idx = '0;
    logic             issue_ack = 1'b0;
    logic             sel_vld;
    logic [PTR_W-1:0] sel_idx;
    logic             retire_vld = 1'b0;
    logic             flush_vld = 1'b0;
    logic [PTR_W-1:0] flush_ptr = '0;
    logic [DEPTH-1:0] valid_vec;
    logic [PTR_W:0]   count;
    logic             empty;
    logic             full;

    always #5 clk = ~clk;

    age_queue_sel #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_dut (
        .clk(clk), .rst(rst),
        .alloc_vld(alloc_vld), .alloc_rdy(alloc_rdy), .alloc_ptr(alloc_ptr),
        .wake_vld(wake_vld), .wake_idx(wake_idx), .issue_ack(issue_ack),
        .sel_vld(sel_vld), .sel_idx(sel_idx),
        .retire_vld(retire_vld), .flush_vld(flush_vld), .flush_ptr(flush_ptr),
        .valid_vec(valid_vec), .count(count), .empty(empty), .full(full)
    );

    typedef struct {
        int cnt; int vv; int sv; int si; int ap; int fl; int em;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    int   m_in, m_out, m_sv, m_si;
    bit   mv[DEPTH];
    bit   mr[DEPTH];
    bit   mi[DEPTH];

    task automatic check_val(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_in = 0; m_out = 0; m_sv = 0; m_si = 0;
        for (int j = 0; j < DEPTH; j++) begin
            mv[j] = 0; mr[j] = 0; mi[j] = 0;
        end
    endtask

    // Advance the model by one cycle and push the outputs it predicts.
    task automatic m_step(input bit a, input bit r, input bit w, input int wi,
                          input bit k, input bit f, input int fp);
        int   cnt, oi, ii, nin, nout, age, j, vv;
        bit   nv[DEPTH], nr[DEPTH], ni[DEPTH];
        exp_t e;
        cnt = (m_in - m_out) & 15;
        oi  = m_out & 7;
        ii  = m_in & 7;
        nv = mv; nr = mr; ni = mi;
        nin = m_in; nout = m_out;
        if (w && mv[wi]) nr[wi] = 1;
        if (k && m_sv) ni[m_si] = 1;
        if (f && mv[fp]) begin
            age = (fp - oi) & 7;
            for (int q = age + 1; q < cnt; q++) begin
                j = (oi + q) & 7;
                nv[j] = 0; nr[j] = 0; ni[j] = 0;
            end
            nin = (m_out + age + 1) & 15;
        end
        if (r && cnt != 0) begin
            nv[oi] = 0; nr[oi] = 0; ni[oi] = 0;
            nout = (m_out + 1) & 15;
        end
        if (a && cnt != DEPTH && !f) begin
            nv[ii] = 1; nr[ii] = 0; ni[ii] = 0;
            nin = (m_in + 1) & 15;
        end
        m_sv = 0; m_si = 0;
        for (int q = DEPTH - 1; q >= 0; q--) begin
            j = (nout + q) & 7;
            if (nv[j] && nr[j] && !ni[j]) begin
                m_sv = 1; m_si = j;
            end
        end
        mv = nv; mr = nr; mi = ni; m_in = nin; m_out = nout;
        vv = 0;
        for (int q = 0; q < DEPTH; q++) if (mv[q]) vv |= (1 << q);
        e.cnt = (m_in - m_out) & 15;
        e.vv  = vv;
        e.sv  = m_sv;
        e.si  = m_si;
        e.ap  = m_in & 7;
        e.fl  = (e.cnt == DEPTH) ? 1 : 0;
        e.em  = (e.cnt == 0) ? 1 : 0;
        sb.push_back(e);
    endtask

    task automatic step(input bit a, input bit r, input bit w, input int wi,
                        input bit k, input bit f, input int fp);
        exp_t e;
        @(negedge clk);
        alloc_vld  = a;
        retire_vld = r;
        wake_vld   = w;
        wake_idx   = PTR_W'(wi);
        issue_ack  = k;
        flush_vld  = f;
        flush_ptr  = PTR_W'(fp);
        m_step(a, r, w, wi, k, f, fp);
        @(posedge clk);
        #1;
        alloc_vld = 0; retire_vld = 0; wake_vld = 0; issue_ack = 0; flush_vld = 0;
        if (sb.size() == 0) begin
            check_val("scoreboard_underflow", 0, 1);
        end else begin
            e = sb.pop_front();
            check_val("count",     int'(count),     e.cnt);
            check_val("valid_vec", int'(valid_vec), e.vv);
            check_val("sel_vld",   int'(sel_vld),   e.sv);
            if (e.sv != 0) check_val("sel_idx", int'(sel_idx), e.si);
            check_val("alloc_ptr", int'(alloc_ptr), e.ap);
            check_val("full",      int'(full),      e.fl);
            check_val("empty",     int'(empty),     e.em);
            check_val("alloc_rdy", int'(alloc_rdy), 1 - e.fl);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        m_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_count",     int'(count),     0);
        check_val("rst_empty",     int'(empty),     1);
        check_val("rst_full",      int'(full),      0);
        check_val("rst_alloc_rdy", int'(alloc_rdy), 1);
        check_val("rst_sel_vld",   int'(sel_vld),   0);
        @(negedge clk);
        rst = 1'b0;

        // Reset asserted mid-traffic takes effect immediately.
        repeat (5) step(1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 2, 0, 0, 0);
        check_val("pre_rst_sel_vld", int'(sel_vld), 1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_val("async_count",     int'(count),     0);
        check_val("async_empty",     int'(empty),     1);
        check_val("async_sel_vld",   int'(sel_vld),   0);
        check_val("async_alloc_rdy", int'(alloc_rdy), 1);
        m_reset();
        @(negedge clk);
        rst = 1'b0;

        // Fill and overflow.
        repeat (8) step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        check_val("ovf_full",      int'(full),      1);
        check_val("ovf_alloc_rdy", int'(alloc_rdy), 0);
        check_val("ovf_count",     int'(count),     8);
        check_val("ovf_alloc_ptr", int'(alloc_ptr), 0);

        // Rotated select across the wrap: out=6, in=3 wrapped.
        repeat (6) step(0, 1, 0, 0, 0, 0, 0);
        repeat (3) step(1, 0, 0, 0, 0, 0, 0);
        check_val("rot_count", int'(count), 5);
        step(0, 0, 1, 1, 0, 0, 0);
        step(0, 0, 1, 7, 0, 0, 0);
        check_val("rot_sel_idx", int'(sel_idx), 7);
        step(0, 0, 0, 0, 1, 0, 0);
        check_val("ack_sel_idx", int'(sel_idx), 1);
        step(0, 0, 0, 0, 1, 0, 0);
        check_val("ack_sel_vld", int'(sel_vld), 0);

        // Flush: out=2, in=7, keep up to 4.
        do_reset();
        repeat (7) step(1, 0, 0, 0, 0, 0, 0);
        repeat (2) step(0, 1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 4);
        check_val("fl_valid_vec", int'(valid_vec), 8'h1C);
        check_val("fl_count",     int'(count),     3);
        check_val("fl_alloc_ptr", int'(alloc_ptr), 5);
        step(0, 0, 0, 0, 0, 1, 0);
        check_val("fl_inv_valid_vec", int'(valid_vec), 8'h1C);

        // Alloc + flush + wake on flushed entry in one cycle.
        step(1, 0, 1, 4, 0, 1, 2);
        check_val("afw_valid_vec", int'(valid_vec), 8'h04);
        check_val("afw_count",     int'(count),     1);
        check_val("afw_sel_vld",   int'(sel_vld),   0);

        // Retire + flush of the only entry leaves the queue empty.
        step(0, 1, 0, 0, 0, 1, 2);
        check_val("rf_empty",     int'(empty),     1);
        check_val("rf_count",     int'(count),     0);
        check_val("rf_alloc_ptr", int'(alloc_ptr), 3);
        step(0, 1, 0, 0, 0, 0, 0);
        check_val("rt_empty_count", int'(count), 0);

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            step($urandom_range(0, 9) < 6,
                 $urandom_range(0, 9) < 3,
                 $urandom_range(0, 9) < 7, $urandom_range(0, 7),
                 $urandom_range(0, 1) == 1,
                 $urandom_range(0, 11) == 0, $urandom_range(0, 7));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
